data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: word-address bits used to index storage (2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter LATENCY, default 4: stall cycles per access; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port addr, input, 16: word address from the EX/MEM stage.
REQ-006 SHALL have port re, input, 1: load request.
REQ-007 SHALL have port we, input, 1: store request.
REQ-008 SHALL have port wrt_data, input, 16: store data.
REQ-009 SHALL have port rd_data, output, 16: load result, registered.
REQ-010 SHALL have port stall, output, 1: pipeline hold request to the CPU.
REQ-011 SHALL have port err, output, 1: sticky flag for simultaneous re and we.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-013 IDLE with re|we high SHALL drive stall high combinationally in that same cycle, then latch addr[ADDR_W-1:0], wrt_data and the op at the clock edge.
REQ-014 IDLE with re|we high SHALL go to DONE when LATENCY=1, else to BUSY with cycle counter loaded to LATENCY-2.
REQ-015 BUSY SHALL hold stall high and decrement the counter; at counter 0 it SHALL go to DONE.
REQ-016 stall SHALL therefore be high for exactly LATENCY consecutive cycles per access.
REQ-017 DONE SHALL drive stall low for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Requests seen during DONE SHALL be treated as the completing access, not as new ones.
REQ-019 A load SHALL update rd_data with mem[latched addr] at the edge entering DONE.
REQ-020 rd_data SHALL hold that value until the next load completes.
REQ-021 A store SHALL write latched wrt_data to mem[latched addr] at the edge entering DONE.
REQ-022 rd_data SHALL be unchanged by stores.
REQ-023 re&we both high at acceptance SHALL be performed as a store and SHALL set err.
REQ-024 err SHALL stay high until reset.
REQ-025 addr bits above ADDR_W-1 SHALL be ignored, so addresses wrap modulo 2^ADDR_W.
REQ-026 Changes on addr, wrt_data, re and we during BUSY or DONE SHALL have no effect.
REQ-027 Back-to-back accesses SHALL each pay full latency: minimum period LATENCY+1 cycles.
REQ-028 In IDLE with re=we=0, stall SHALL be low and no state SHALL change.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, counter 0, rd_data 0, err 0 and stall 0.
REQ-030 Reset asserted mid-access SHALL abort the access; no memory write SHALL occur.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Structure
REQ-033 The shared CPU package SHALL hold the FSM state encoding, the 16-bit word width constant and the default LATENCY.
REQ-034 The storage array SHALL be a single sub-module, dm_array (one synchronous write port, one read port), instantiated once.
REQ-035 FSM, counter and output registers SHALL live in data_mem_ctrl.

Verification
REQ-036 Store: LATENCY=4, we=1, addr=0x0010, wrt_data=0xBEEF. Then load addr 0x0010 -> stall high 4 cycles per access; rd_data=0xBEEF in the load's DONE cycle.
REQ-037 Minimum latency: LATENCY=1, re=1 held continuously -> stall alternates 1,0; one access completes every 2 cycles.
REQ-038 Address wrap: ADDR_W=12, store 0x1234 at addr 0xF005. Load addr 0x0005 -> rd_data=0x1234.
REQ-039 Simultaneous requests: re=we=1, wrt_data=0x00AA, addr=3 -> mem[3]=0x00AA, rd_data unchanged, err=1 persistent.
REQ-040 Reset mid-access: store 0x5555 to addr 7 (pre-loaded with 0x1111), rst_n low in BUSY cycle 2 -> stall, rd_data, err 0 at once; later load of addr 7 returns 0x1111.
REQ-041 Input change: addr changed mid-BUSY from 0x20 to 0x30 on a load -> rd_data reflects mem[0x20].

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared CPU constants and the data-memory controller state encoding.
package data_mem_ctrl_pkg;
  localparam int WORD_W = 16;
  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/dm_array.sv
// dm_array: word storage with one synchronous write port and one asynchronous read port.
module dm_array
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: fixed-latency data-memory controller that stalls the CPU for LATENCY cycles per access.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [15:0]       wrt_data,
  output logic [WORD_W-1:0] rd_data,
  output logic              stall,
  output logic              err
);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               op_we_q, op_we_d;
  logic [WORD_W-1:0]  rd_data_q, rd_data_d;
  logic               err_q, err_d;
  logic               idle, req, finish, acc_we, mem_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [WORD_W-1:0]  acc_data, mem_rdata;
  logic               addr_unused;
  assign addr_unused = ^(addr >> ADDR_W);
  assign idle = state_q == IDLE;
  assign req = re | we;
  // With LATENCY=1 the access finishes on the accepting edge, so the live inputs feed the array.
  assign acc_addr = idle ? addr[ADDR_W-1:0] : addr_q;
  assign acc_data = idle ? wrt_data : wdata_q;
  assign acc_we = idle ? we : op_we_q;
  assign finish = (idle && req && LATENCY == 1) || (state_q == BUSY && cnt_q == '0);
  assign mem_we = rst_n && finish && acc_we;
  assign stall = rst_n && ((idle && req) || state_q == BUSY);
  assign rd_data = rd_data_q;
  assign err = err_q;
  dm_array #(.ADDR_W(ADDR_W), .DATA_W(WORD_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (acc_addr),
    .wdata (acc_data),
    .raddr (acc_addr),
    .rdata (mem_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    op_we_d = op_we_q;
    err_d = err_q;
    if (idle && req) begin
      state_d = (LATENCY == 1) ? DONE : BUSY;
      cnt_d = CNT_LOAD;
      addr_d = addr[ADDR_W-1:0];
      wdata_d = wrt_data;
      op_we_d = we;
      err_d = err_q | (re & we);
    end else if (state_q == BUSY) begin
      state_d = (cnt_q == '0) ? DONE : BUSY;
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    rd_data_d = (finish && !acc_we) ? mem_rdata : rd_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      op_we_q <= 1'b0;
      rd_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      op_we_q <= op_we_d;
      rd_data_q <= rd_data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench for data_mem_ctrl against a transaction-level model.
module tb_data_mem_ctrl;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic re = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rd_data;
  logic stall, err;
  logic re1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = '0, wdata1 = '0;
  logic [15:0] rd1;
  logic stall1, err1;
  data_mem_ctrl #(.ADDR_W(12), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we),
    .wrt_data(wdata), .rd_data(rd_data), .stall(stall), .err(err)
  );
  data_mem_ctrl #(.ADDR_W(12), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr1), .re(re1), .we(we1),
    .wrt_data(wdata1), .rd_data(rd1), .stall(stall1), .err(err1)
  );
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Transaction model: an accepted access owes L stall cycles, then one quiet completion cycle.
  logic [15:0] mem_m [4096];
  bit val_m [4096];
  int rem = 0;
  bit in_done = 0;
  logic [11:0] t_a;
  logic [15:0] t_d;
  bit t_w;
  logic [15:0] rd_m = '0;
  bit rd_known = 1;
  bit err_m = 0;
  int stall_seen;
  function automatic void complete();
    in_done = 1;
    if (t_w) begin
      mem_m[t_a] = t_d;
      val_m[t_a] = 1;
    end else begin
      rd_known = val_m[t_a];
      rd_m = mem_m[t_a];
    end
  endfunction
  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    re = r; we = w; addr = a; wdata = d;
    #1;
    chk("stall", {15'b0, stall}, {15'b0, (rem > 0) || (!in_done && (r || w))});
    if (stall) stall_seen++;
    if (rd_known) chk("rd_data", rd_data, rd_m);
    chk("err", {15'b0, err}, {15'b0, err_m});
    @(posedge clk);
    if (in_done) in_done = 0;
    else if (rem > 0) begin
      rem--;
      if (rem == 0) complete();
    end else if (r || w) begin
      t_a = a[11:0]; t_d = d; t_w = w;
      if (r && w) err_m = 1;
      rem = L - 1;
      if (rem == 0) complete();
    end
  endtask
  task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int nstall);
    int guard = 0;
    stall_seen = 0;
    step(r, w, a, d);
    while (!in_done && guard < 20) begin
      step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      guard++;
    end
    if (!in_done) begin
      errors++;
      $display("FAIL access_timeout: got no completion expected one within 20 cycles");
    end
    step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    nstall = stall_seen;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ns;
    #1;
    chk("rst_stall", {15'b0, stall}, 16'h0);
    chk("rst_rd", rd_data, 16'h0);
    chk("rst_err", {15'b0, err}, 16'h0);
    re = 1'b1; re1 = 1'b1;
    #1;
    chk("rst_stall_req", {15'b0, stall}, 16'h0);
    chk("rst_stall1_req", {15'b0, stall1}, 16'h0);
    re = 1'b0; re1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, ns);
    chk("store_stall_cnt", 16'(ns), 16'd4);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, ns);
    chk("load_stall_cnt", 16'(ns), 16'd4);
    chk("load_beef", rd_data, 16'hBEEF);
    access(1'b0, 1'b1, 16'hF005, 16'h1234, ns);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, ns);
    chk("wrap_load", rd_data, 16'h1234);
    access(1'b0, 1'b1, 16'h0020, 16'hAAAA, ns);
    access(1'b0, 1'b1, 16'h0030, 16'h3333, ns);
    step(1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b1, 1'b0, 16'h0030, 16'h0000);
    step(1'b0, 1'b1, 16'h0030, 16'h7777);
    step(1'b1, 1'b1, 16'h0030, 16'h8888);
    step(1'b1, 1'b0, 16'h0030, 16'h0000);
    chk("busy_addr_change", rd_data, 16'hAAAA);
    access(1'b1, 1'b1, 16'h0003, 16'h00AA, ns);
    chk("both_rd_kept", rd_data, 16'hAAAA);
    chk("both_err", {15'b0, err}, 16'h1);
    access(1'b1, 1'b0, 16'h0003, 16'h0000, ns);
    chk("both_stored", rd_data, 16'h00AA);
    chk("err_sticky", {15'b0, err}, 16'h1);
    for (int j = 0; j < 16; j++)
      access(1'b0, 1'b1, {4'($urandom), 8'h00, 4'(j)}, 16'($urandom), ns);
    for (int n = 0; n < 200; n++) begin
      int gap = $urandom_range(0, 2);
      int k = $urandom_range(0, 7);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      access(k < 4 || k == 7, k >= 4, {4'($urandom), 8'h00, 4'($urandom)}, 16'($urandom), ns);
      chk("rand_stall_cnt", 16'(ns), 16'd4);
    end
    access(1'b0, 1'b1, 16'h0007, 16'h1111, ns);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, ns);
    step(1'b0, 1'b1, 16'h0007, 16'h5555);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_stall", {15'b0, stall}, 16'h0);
    chk("abort_rd", rd_data, 16'h0);
    chk("abort_err", {15'b0, err}, 16'h0);
    rem = 0; in_done = 0; rd_m = '0; rd_known = 1; err_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 16'h0007, 16'h0000, ns);
    chk("abort_no_write", rd_data, 16'h1111);
    @(negedge clk);
    we1 = 1'b1; addr1 = 16'h0005; wdata1 = 16'hC0DE;
    #1 chk("l1_st_a", {15'b0, stall1}, 16'h1);
    @(negedge clk);
    addr1 = 16'h0006; wdata1 = 16'h0F0F;
    #1 chk("l1_st_done", {15'b0, stall1}, 16'h0);
    @(negedge clk);
    #1 chk("l1_st_b", {15'b0, stall1}, 16'h1);
    @(negedge clk);
    we1 = 1'b0;
    #1 chk("l1_st_done2", {15'b0, stall1}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      re1 = 1'b1;
      addr1 = (i % 2 == 1) ? 16'($urandom) : ((i % 4 == 0) ? 16'h0005 : 16'h0006);
      #1;
      chk("l1_stall", {15'b0, stall1}, {15'b0, i % 2 == 0});
      if (i % 2 == 1) chk("l1_rd", rd1, (i % 4 == 1) ? 16'hC0DE : 16'h0F0F);
    end
    chk("l1_err", {15'b0, err1}, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
